// File: rtl/pipeline_ctrl_pkg.sv
// Shared types and opcode constants for the pipeline hazard controller.
// Used by pipeline_hazard_controller and forwarding_unit.
package pipeline_ctrl_pkg;

  localparam logic [5:0] BEQ = 6'b000100;
  localparam logic [5:0] BNE = 6'b000101;
  localparam logic [5:0] J   = 6'b000010;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_t;

  typedef enum logic [1:0] {
    PC_PLUS4  = 2'b00,
    PC_BRANCH = 2'b01,
    PC_JUMP   = 2'b10
  } pc_src_t;

  typedef enum logic [1:0] {
    RUN     = 2'b00,
    MEMWAIT = 2'b01,
    ABORT   = 2'b10
  } mem_state_t;

  // A writing stage hits a source register; $0 never matches.
  function automatic logic reg_hit(input logic       we,
                                   input logic [4:0] dst,
                                   input logic [4:0] src);
    return we && (dst != 5'd0) && (dst == src);
  endfunction

endpackage

// File: rtl/pipeline_hazard_controller_fwd.sv
// EX-stage operand forwarding select (module forwarding_unit), purely combinational.
// MEM-stage results take precedence over WB-stage results.
module forwarding_unit
  import pipeline_ctrl_pkg::*;
(
  input  logic [4:0] EXRs,
  input  logic [4:0] EXRt,
  input  logic [4:0] MEMWriteReg,
  input  logic [4:0] WBWriteReg,
  input  logic       MEMRegWrite,
  input  logic       WBRegWrite,
  output fwd_sel_t   forwardA,
  output fwd_sel_t   forwardB
);

  always_comb begin
    forwardA = FWD_RF;
    if (reg_hit(MEMRegWrite, MEMWriteReg, EXRs))
      forwardA = FWD_MEM;
    else if (reg_hit(WBRegWrite, WBWriteReg, EXRs))
      forwardA = FWD_WB;
  end

  always_comb begin
    forwardB = FWD_RF;
    if (reg_hit(MEMRegWrite, MEMWriteReg, EXRt))
      forwardB = FWD_MEM;
    else if (reg_hit(WBRegWrite, WBWriteReg, EXRt))
      forwardB = FWD_WB;
  end

endmodule

// File: rtl/pipeline_hazard_controller.sv
// Hazard, forwarding, PC steering and data-memory wait control for the 5-stage MIPS pipe.
// Optional performance counters are built when PERF_COUNTERS_EN is defined.
//
// state   | meaning
// --------+-----------------------------------------------------------
// RUN     | normal flow; a pending MEM access without ready freezes
// MEMWAIT | waiting on data memory, pipeline frozen until ready/timeout
// ABORT   | timed out; one unfrozen cycle lets the access retire
module pipeline_hazard_controller
  import pipeline_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
)(
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      inst,
  input  logic             equal,
  input  logic [4:0]       Rs,
  input  logic [4:0]       Rt,
  input  logic [4:0]       EXRs,
  input  logic [4:0]       EXRt,
  input  logic [4:0]       EXWriteReg,
  input  logic [4:0]       MEMWriteReg,
  input  logic [4:0]       WBWriteReg,
  input  logic             EXMemRead,
  input  logic             EXRegWrite,
  input  logic             MEMRegWrite,
  input  logic             WBRegWrite,
  input  logic             MEMMemAccess,
  input  logic             dmemReady,
  output logic             PCWrite,
  output logic             IFIDWrite,
  output logic             IFflush,
  output logic             bubble,
  output logic             freeze,
  output logic [1:0]       forwardA,
  output logic [1:0]       forwardB,
  output logic [1:0]       PCSrc,
  output logic             memErr
`ifdef PERF_COUNTERS_EN
  ,
  output logic [CNT_W-1:0] cycleCount,
  output logic [CNT_W-1:0] stallCount,
  output logic [CNT_W-1:0] flushCount
`endif
);

  // Down-counter of remaining freeze cycles after the first; terminal count at zero.
  localparam int              WCW       = $clog2(MEM_TIMEOUT);
  localparam logic [WCW-1:0]  WAIT_LOAD = WCW'(MEM_TIMEOUT - 2);

  mem_state_t     state, state_nxt;
  logic [WCW-1:0] wait_cnt;
  logic           wait_tc;
  logic           mem_start;
  logic           freeze_raw;
  logic           load_use;
  logic           br_stall;
  logic           stall;
  logic [5:0]     opcode;
  logic           is_branch;
  logic           br_taken;
  fwd_sel_t       fwd_a, fwd_b;
  pc_src_t        pc_src;
  logic           unused_inst;

  assign opcode      = inst[31:26];
  assign unused_inst = ^inst[25:0];
  assign wait_tc     = (wait_cnt == '0);

  forwarding_unit u_fwd (
    .EXRs        (EXRs),
    .EXRt        (EXRt),
    .MEMWriteReg (MEMWriteReg),
    .WBWriteReg  (WBWriteReg),
    .MEMRegWrite (MEMRegWrite),
    .WBRegWrite  (WBRegWrite),
    .forwardA    (fwd_a),
    .forwardB    (fwd_b)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= RUN;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      RUN:     if (mem_start) state_nxt = MEMWAIT;
      MEMWAIT: if (dmemReady) state_nxt = RUN;
               else if (wait_tc) state_nxt = ABORT;
      ABORT:   state_nxt = RUN;
      default: state_nxt = RUN;
    endcase
  end

  always_comb begin
    mem_start  = (state == RUN) && MEMMemAccess && !dmemReady;
    freeze_raw = mem_start || ((state == MEMWAIT) && !dmemReady);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt <= '0;
    end else if (state == RUN) begin
      wait_cnt <= mem_start ? WAIT_LOAD : '0;
    end else if ((state == MEMWAIT) && !dmemReady && !wait_tc) begin
      wait_cnt <= wait_cnt - WCW'(1);
    end else if (state == ABORT) begin
      wait_cnt <= '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      memErr <= 1'b0;
    else if ((state == MEMWAIT) && !dmemReady && wait_tc)
      memErr <= 1'b1;
  end

  always_comb begin
    load_use  = EXMemRead && (EXRt != 5'd0) && ((EXRt == Rs) || (EXRt == Rt));
    is_branch = (opcode == BEQ) || (opcode == BNE);
    br_stall  = is_branch &&
                (reg_hit(EXRegWrite,  EXWriteReg,  Rs) || reg_hit(EXRegWrite,  EXWriteReg,  Rt) ||
                 reg_hit(MEMRegWrite, MEMWriteReg, Rs) || reg_hit(MEMRegWrite, MEMWriteReg, Rt) ||
                 reg_hit(WBRegWrite,  WBWriteReg,  Rs) || reg_hit(WBRegWrite,  WBWriteReg,  Rt));
    stall     = load_use || br_stall;
    br_taken  = ((opcode == BEQ) && equal) || ((opcode == BNE) && !equal);
  end

  // Priority: reset > freeze > stall > steering.
  always_comb begin
    PCWrite   = 1'b1;
    IFIDWrite = 1'b1;
    IFflush   = 1'b0;
    bubble    = 1'b0;
    freeze    = 1'b0;
    pc_src    = PC_PLUS4;
    if (rst) begin
      PCWrite   = 1'b0;
      IFIDWrite = 1'b0;
    end else if (freeze_raw) begin
      freeze    = 1'b1;
      PCWrite   = 1'b0;
      IFIDWrite = 1'b0;
    end else if (stall) begin
      PCWrite   = 1'b0;
      IFIDWrite = 1'b0;
      bubble    = 1'b1;
    end else if (br_taken) begin
      pc_src  = PC_BRANCH;
      IFflush = 1'b1;
    end else if (opcode == J) begin
      pc_src  = PC_JUMP;
      IFflush = 1'b1;
    end
  end

  assign PCSrc    = pc_src;
  assign forwardA = rst ? FWD_RF : fwd_a;
  assign forwardB = rst ? FWD_RF : fwd_b;

`ifdef PERF_COUNTERS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cycleCount <= '0;
      stallCount <= '0;
      flushCount <= '0;
    end else begin
      if (cycleCount != '1)
        cycleCount <= cycleCount + CNT_W'(1);
      if ((stall || freeze_raw) && (stallCount != '1))
        stallCount <= stallCount + CNT_W'(1);
      if (IFflush && (flushCount != '1))
        flushCount <= flushCount + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Directed and randomized bench for pipeline_hazard_controller against a rule-level model.
module tb_pipeline_hazard_controller;

  localparam int TO    = 8;
  localparam int CNT_W = 32;
  localparam logic [5:0] OP_BEQ = 6'b000100;
  localparam logic [5:0] OP_BNE = 6'b000101;
  localparam logic [5:0] OP_J   = 6'b000010;
  localparam logic [5:0] OP_LW  = 6'b100011;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [31:0] inst = '0;
  logic equal = 1'b0;
  logic [4:0] Rs = '0, Rt = '0, EXRs = '0, EXRt = '0;
  logic [4:0] EXWriteReg = '0, MEMWriteReg = '0, WBWriteReg = '0;
  logic EXMemRead = 1'b0, EXRegWrite = 1'b0, MEMRegWrite = 1'b0, WBRegWrite = 1'b0;
  logic MEMMemAccess = 1'b0, dmemReady = 1'b0;
  logic PCWrite, IFIDWrite, IFflush, bubble, freeze, memErr;
  logic [1:0] forwardA, forwardB, PCSrc;
`ifdef PERF_COUNTERS_EN
  logic [CNT_W-1:0] cycleCount, stallCount, flushCount;
`endif

  always #5 clk = ~clk;

  pipeline_hazard_controller #(.MEM_TIMEOUT(TO), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .inst(inst), .equal(equal),
    .Rs(Rs), .Rt(Rt), .EXRs(EXRs), .EXRt(EXRt),
    .EXWriteReg(EXWriteReg), .MEMWriteReg(MEMWriteReg), .WBWriteReg(WBWriteReg),
    .EXMemRead(EXMemRead), .EXRegWrite(EXRegWrite), .MEMRegWrite(MEMRegWrite),
    .WBRegWrite(WBRegWrite), .MEMMemAccess(MEMMemAccess), .dmemReady(dmemReady),
    .PCWrite(PCWrite), .IFIDWrite(IFIDWrite), .IFflush(IFflush), .bubble(bubble),
    .freeze(freeze), .forwardA(forwardA), .forwardB(forwardB), .PCSrc(PCSrc),
    .memErr(memErr)
`ifdef PERF_COUNTERS_EN
    , .cycleCount(cycleCount), .stallCount(stallCount), .flushCount(flushCount)
`endif
  );

  int ncmp = 0;
  int nerr = 0;

  // Model of the memory access: freeze cycles spent on the current access.
  bit m_waiting = 0;
  bit m_abort   = 0;
  bit m_err     = 0;
  int m_spent   = 0;
  logic last_frz;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] m_fwd(input logic [4:0] r);
    if (r == 5'd0) return 2'b00;
    if (MEMRegWrite && MEMWriteReg == r) return 2'b10;
    if (WBRegWrite && WBWriteReg == r) return 2'b01;
    return 2'b00;
  endfunction

  function automatic bit m_freeze();
    if (rst || m_abort) return 0;
    if (dmemReady) return 0;
    return m_waiting || MEMMemAccess;
  endfunction

  function automatic bit m_stall();
    logic [4:0] dst[3];
    bit         wen[3];
    logic [4:0] src[2];
    bit lu, br;
    logic [5:0] op;
    op  = inst[31:26];
    dst = '{EXWriteReg, MEMWriteReg, WBWriteReg};
    wen = '{EXRegWrite, MEMRegWrite, WBRegWrite};
    src = '{Rs, Rt};
    lu  = EXMemRead && EXRt != 0 && (EXRt == Rs || EXRt == Rt);
    br  = 0;
    if (op == OP_BEQ || op == OP_BNE)
      foreach (src[s]) foreach (dst[d])
        if (src[s] != 0 && wen[d] && dst[d] == src[s]) br = 1;
    return lu || br;
  endfunction

  task automatic check_all();
    bit frz, stl;
    logic [5:0] op;
    logic e_pcw, e_ifid, e_flush, e_bub;
    logic [1:0] e_pc, e_fa, e_fb;
    op   = inst[31:26];
    frz  = m_freeze();
    stl  = m_stall();
    e_pcw = 1; e_ifid = 1; e_flush = 0; e_bub = 0; e_pc = 0;
    e_fa = m_fwd(EXRs);
    e_fb = m_fwd(EXRt);
    if (rst) begin
      e_pcw = 0; e_ifid = 0; e_fa = 0; e_fb = 0;
    end else if (frz) begin
      e_pcw = 0; e_ifid = 0;
    end else if (stl) begin
      e_pcw = 0; e_ifid = 0; e_bub = 1;
    end else if ((op == OP_BEQ && equal) || (op == OP_BNE && !equal)) begin
      e_pc = 2'b01; e_flush = 1;
    end else if (op == OP_J) begin
      e_pc = 2'b10; e_flush = 1;
    end
    chk("PCWrite",   8'(PCWrite),   8'(e_pcw));
    chk("IFIDWrite", 8'(IFIDWrite), 8'(e_ifid));
    chk("IFflush",   8'(IFflush),   8'(e_flush));
    chk("bubble",    8'(bubble),    8'(e_bub));
    chk("freeze",    8'(freeze),    8'(frz));
    chk("forwardA",  8'(forwardA),  8'(e_fa));
    chk("forwardB",  8'(forwardB),  8'(e_fb));
    chk("PCSrc",     8'(PCSrc),     8'(e_pc));
    chk("memErr",    8'(memErr),    8'(m_err && !rst));
    last_frz = freeze;
  endtask

  task automatic tick();
    bit frz;
    frz = m_freeze();
    @(posedge clk);
    if (rst) begin
      m_waiting = 0; m_abort = 0; m_err = 0; m_spent = 0;
    end else if (frz) begin
      m_spent++;
      if (m_spent == TO) begin
        m_abort = 1; m_err = 1; m_waiting = 0; m_spent = 0;
      end else begin
        m_waiting = 1;
      end
    end else begin
      m_waiting = 0; m_abort = 0; m_spent = 0;
    end
    #1;
  endtask

  task automatic step();
    #2;
    check_all();
    tick();
  endtask

  task automatic idle();
    inst = '0; equal = 0; Rs = 0; Rt = 0; EXRs = 0; EXRt = 0;
    EXWriteReg = 0; MEMWriteReg = 0; WBWriteReg = 0;
    EXMemRead = 0; EXRegWrite = 0; MEMRegWrite = 0; WBRegWrite = 0;
    MEMMemAccess = 0; dmemReady = 0;
  endtask

  task automatic randomize_inputs();
    logic [5:0] ops[5];
    ops  = '{6'b000000, OP_BEQ, OP_BNE, OP_J, OP_LW};
    inst = {ops[$urandom_range(0, 4)], 26'($urandom)};
    equal = 1'($urandom);
    Rs = 5'($urandom_range(0, 7)); Rt = 5'($urandom_range(0, 7));
    EXRs = 5'($urandom_range(0, 7)); EXRt = 5'($urandom_range(0, 7));
    EXWriteReg = 5'($urandom_range(0, 7));
    MEMWriteReg = 5'($urandom_range(0, 7));
    WBWriteReg = 5'($urandom_range(0, 7));
    EXMemRead = 1'($urandom); EXRegWrite = 1'($urandom);
    MEMRegWrite = 1'($urandom); WBRegWrite = 1'($urandom);
    MEMMemAccess = ($urandom_range(0, 3) == 0);
    dmemReady = ($urandom_range(0, 2) != 0);
  endtask

  initial begin
    int n;
    rst = 1;
    idle();
    @(posedge clk); #1;
    randomize_inputs();
    step();
    rst = 0;
    idle();
    step();

    // load-use: EX lw $8, ID add $9,$8,$3
    EXMemRead = 1; EXRegWrite = 1; EXWriteReg = 8; EXRt = 8; Rs = 8; Rt = 3;
    #2;
    chk("lu_bubble", 8'(bubble), 8'd1);
    chk("lu_pcwrite", 8'(PCWrite), 8'd0);
    #0 step();
    idle(); WBRegWrite = 1; WBWriteReg = 8; EXRs = 8;
    #2;
    chk("lu_fwdA_wb", 8'(forwardA), 8'd1);
    #0 step();

    idle(); MEMRegWrite = 1; MEMWriteReg = 5; WBRegWrite = 1; WBWriteReg = 5; EXRs = 5;
    step();
    MEMWriteReg = 0;
    step();
    EXRt = 5; EXRs = 0; MEMWriteReg = 5;
    step();

    idle(); inst = {OP_BEQ, 26'h0}; equal = 1; Rs = 1; Rt = 2;
    step();
    inst = {OP_J, 26'h123};
    step();
    inst = {OP_BNE, 26'h0}; equal = 1;
    step();
    equal = 0;
    step();
    idle(); inst = {OP_BEQ, 26'h0}; equal = 1; Rs = 4; Rt = 2; EXRegWrite = 1; EXWriteReg = 4;
    #2;
    chk("br_stall_pcsrc", 8'(PCSrc), 8'd0);
    chk("br_stall_bubble", 8'(bubble), 8'd1);
    #0 step();
    EXRegWrite = 0; WBRegWrite = 1; WBWriteReg = 2;
    step();
    EXMemRead = 1; EXRt = 4; EXRegWrite = 1; EXWriteReg = 2;
    step();

    // three-cycle memory wait
    idle(); MEMMemAccess = 1; dmemReady = 0; inst = {OP_J, 26'h0};
    n = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      if (last_frz) n++;
    end
    dmemReady = 1;
    step();
    if (last_frz) n++;
    chk("wait3_len", 8'(n), 8'd3);
    MEMMemAccess = 0;
    step();

    // timeout: freeze exactly TO cycles, then the abort cycle
    idle(); MEMMemAccess = 1; dmemReady = 0;
    n = 0;
    for (int i = 0; i < 3 * TO; i++) begin
      step();
      if (last_frz) n++;
      else break;
    end
    chk("timeout_len", 8'(n), 8'(TO));
    MEMMemAccess = 0;
    for (int i = 0; i < 3; i++) step();
    chk("memErr_sticky", 8'(memErr), 8'd1);

    for (int i = 0; i < 400; i++) begin
      randomize_inputs();
      step();
    end

    // reset in the middle of a wait: no error, back to RUN
    rst = 1; idle(); step();
    rst = 0; MEMMemAccess = 1; dmemReady = 0;
    step(); step(); step();
    rst = 1;
    #2;
    chk("rst_mid_freeze", 8'(freeze), 8'd0);
    chk("rst_mid_memErr", 8'(memErr), 8'd0);
    #0 step();
    rst = 0; idle();
    step();
    MEMMemAccess = 1; dmemReady = 1;
    step();
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_controller.md
# pipeline_hazard_controller

Central hazard controller for the five-stage pipelined MIPS datapath. It combines load-use and branch-operand stall detection, EX-stage forwarding selection, and branch/jump PC steering with IF flush. It also sequences multi-cycle data-memory accesses through a wait state machine that freezes the whole pipeline, with a bounded timeout. It sits beside the datapath and drives its PCWrite, IFIDWrite, IFflush, forwardA/B and PCSrc inputs, plus the new bubble and freeze controls.

## Interface
- MEM_TIMEOUT, 16: maximum consecutive freeze cycles for one data-memory access (≥2).
- CNT_W, 32: width of performance counters.

Ports:
- clk  in  1  pipeline clock, rising edge.
- rst  in  1  reset; **one clock; reset is asynchronous and active-high**.
- inst  in  32  IF/ID instruction (opcode = inst[31:26]).
- equal  in  1  ID-stage register compare result.
- Rs, Rt  in  5 each  ID-stage source registers.
- EXRs, EXRt  in  5 each  ID/EX source registers.
- EXWriteReg, MEMWriteReg, WBWriteReg  in  5 each  destination register per stage.
- EXMemRead, EXRegWrite, MEMRegWrite, WBRegWrite  in  1 each  stage control bits.
- MEMMemAccess  in  1  MEM stage holds a load or store.
- dmemReady  in  1  data memory completes the access this cycle.
- PCWrite, IFIDWrite, IFflush  out  1 each  IF-stage controls.
- bubble  out  1  zero ID/EX control bits this edge.
- freeze  out  1  hold every pipeline register.
- forwardA, forwardB  out  2 each  00 = register file, 01 = WB data, 10 = MEM ALU result.
- PCSrc  out  2  00 = pc+4, 01 = branch target, 10 = jump target.
- memErr  out  1  sticky timeout flag.
- cycleCount, stallCount, flushCount  out  CNT_W each  present only with PERF_COUNTERS_EN.

## Operation
- **Forwarding (per operand, EXRs→A, EXRt→B):**
  - 10 if MEMRegWrite, MEMWriteReg≠0 and MEMWriteReg matches the operand.
  - Else 01 if WBRegWrite, WBWriteReg≠0 and WBWriteReg matches.
  - Else 00.
- **Load-use stall:** asserted when EXMemRead and EXRt≠0 and EXRt equals Rs or Rt.
- **Branch-operand stall:** asserted when the ID opcode is beq (000100) or bne (000101) and Rs or Rt (non-zero) matches the destination of any writing stage (EX, MEM or WB).
- **Stall effect:** PCWrite=0, IFIDWrite=0, bubble=1, PCSrc=00, IFflush=0.
- **Steering (no stall):**
  - beq taken when equal=1; bne taken when equal=0. Taken gives PCSrc=01 and IFflush=1.
  - j (000010) gives PCSrc=10 and IFflush=1.
  - Otherwise PCSrc=00.
- **Memory FSM states:**
  - RUN: on MEMMemAccess & !dmemReady, go to MEMWAIT.
  - MEMWAIT: on dmemReady go to RUN; on timeout go to ABORT.
  - ABORT: always returns to RUN next cycle.
- **freeze:** (RUN & MEMMemAccess & !dmemReady) | (MEMWAIT & !dmemReady). freeze=0 in ABORT.
- **Wait counter:** counts freeze cycles. When it reaches MEM_TIMEOUT−1 while !dmemReady, the FSM moves to ABORT and memErr sets. The access then advances with undefined load data.
- **Freeze effect and priority:** freeze=1 forces PCWrite=0, IFIDWrite=0, bubble=0, IFflush=0, PCSrc=00. Forwarding selects keep their combinational values. Priority is freeze > stall > steering.

## Timing
- All controls except memErr and the counters are combinational from inputs and state, with zero latency.
- State, the wait counter, memErr and the counters update on the rising clk edge.
- While rst is high:
  - State=RUN, wait counter=0, memErr=0, counters=0.
  - PCWrite=0, IFIDWrite=0, IFflush=0, bubble=0, freeze=0, forwardA/B=00, PCSrc=00.
- Reset mid-wait aborts the access with no memErr.
- dmemReady high in the same cycle the access appears: no freeze, state stays RUN.
- freeze lasts at most MEM_TIMEOUT consecutive cycles per access.
- memErr clears only on rst.
- Load-use and branch stalls coinciding: a single stall cycle is produced per evaluation.
- Register 0 never matches for forwarding or stalls.

## Configuration
- PERF_COUNTERS_EN defined:
  - cycleCount increments every non-reset cycle.
  - stallCount increments on stall or freeze cycles.
  - flushCount increments on IFflush cycles.
  - All counters saturate at all-ones.
- Undefined: counter ports and logic are absent.

## Structure
- Shared package pipeline_ctrl_pkg holds:
  - opcode constants (BEQ, BNE, J);
  - fwd_sel_t and pc_src_t 2-bit enums;
  - mem_state_t {RUN, MEMWAIT, ABORT}.
- Sub-module forwarding_unit: combinational, instantiated once, computes forwardA/B.

## Test plan
- EX lw writing $8, ID add $9,$8,$3 → one cycle with PCWrite=0, IFIDWrite=0, bubble=1; next cycle forwardA=01.
- MEM writes $5 and WB writes $5, EXRs=5 → forwardA=10; with MEMWriteReg=0 instead → forwardA=01.
- ID beq with equal=1 and no hazards → PCSrc=01, IFflush=1; j → PCSrc=10, IFflush=1; bne with equal=1 → PCSrc=00.
- ID beq $4 while EX writes $4 → stall with PCSrc=00 and no flush.
- MEMMemAccess with dmemReady low for 3 cycles then high → freeze high exactly 3 cycles; PCWrite=0 throughout; memErr stays 0.
- MEM_TIMEOUT=8, dmemReady held low → freeze high exactly 8 cycles, then ABORT; memErr=1 and holds until rst.
